// File: rtl/pipeline_hazard_controller.sv
// Hazard, flush and halt/drain sequencing for the five-stage LEGv8 pipeline.
// Define PIPELINE_HAZARD_PERF_EN to build the stall/flush performance counters.
module pipeline_hazard_controller #(
    parameter int CNT_WIDTH    = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic [4:0]           IFID_rn,
    input  logic [4:0]           IFID_rm,
    input  logic                 IFID_usesRm,
    input  logic                 IDEX_RegWrite,
    input  logic                 EXMEM_RegWrite,
    input  logic                 MEMWB_RegWrite,
    input  logic [4:0]           IDEX_WriteReg,
    input  logic [4:0]           EXMEM_WriteReg,
    input  logic [4:0]           MEMWB_WriteReg,
    input  logic                 EXMEM_takeBranch,
    input  logic                 haltReq,
    output logic                 PCwrite,
    output logic                 IFIDwrite,
    output logic                 IDEXbubble,
    output logic                 IFIDflush,
    output logic                 IDEXflush,
    output logic                 EXMEMflush,
    output logic                 haltAck,
    output logic [CNT_WIDTH-1:0] stallCycles,
    output logic [CNT_WIDTH-1:0] flushCount
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
    localparam logic [4:0] XZR = 5'd31;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
    logic            halt_ack_q, halt_ack_d;
    logic            raw_haz;
    logic            branch;

    // XZR reads are constant zero, so a write to it never needs to be waited on.
    function automatic logic writer_hits(
        input logic       we,
        input logic [4:0] wr,
        input logic [4:0] rn,
        input logic [4:0] rm,
        input logic       uses_rm
    );
        return we && (wr != XZR) && ((wr == rn) || (uses_rm && (wr == rm)));
    endfunction

    assign branch = EXMEM_takeBranch;

    always_comb begin
        raw_haz = writer_hits(IDEX_RegWrite,  IDEX_WriteReg,  IFID_rn, IFID_rm, IFID_usesRm)
               || writer_hits(EXMEM_RegWrite, EXMEM_WriteReg, IFID_rn, IFID_rm, IFID_usesRm)
               || writer_hits(MEMWB_RegWrite, MEMWB_WriteReg, IFID_rn, IFID_rm, IFID_usesRm);
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (haltReq && !branch) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = haltReq ? ST_HALTED : ST_RUN;
                end else begin
                    drain_cnt_d = drain_cnt_q - DW'(1);
                end
            end
            ST_HALTED: begin
                if (!haltReq) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d     = ST_RUN;
                drain_cnt_d = '0;
            end
        endcase
        halt_ack_d = (state_d == ST_HALTED);
    end

    // A taken branch always wins: the wrong-path instructions must go even while draining.
    always_comb begin
        PCwrite    = 1'b1;
        IFIDwrite  = 1'b1;
        IDEXbubble = 1'b0;
        IFIDflush  = 1'b0;
        IDEXflush  = 1'b0;
        EXMEMflush = 1'b0;
        if (branch) begin
            IFIDflush  = 1'b1;
            IDEXflush  = 1'b1;
            EXMEMflush = 1'b1;
        end else if (state_q != ST_RUN || raw_haz) begin
            PCwrite    = 1'b0;
            IFIDwrite  = 1'b0;
            IDEXbubble = 1'b1;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            halt_ack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            halt_ack_q  <= halt_ack_d;
        end
    end

    assign haltAck = halt_ack_q;

`ifdef PIPELINE_HAZARD_PERF_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    // Both counters stick at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q == ST_RUN && raw_haz && !branch && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
        if (branch && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stallCycles = stall_cnt_q;
    assign flushCount  = flush_cnt_q;
`else
    assign stallCycles = '0;
    assign flushCount  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed scoreboard bench for pipeline_hazard_controller: RAW stalls, XZR, branch flush,
// halt/drain/resume and asynchronous reset; counter expectations follow PIPELINE_HAZARD_PERF_EN.
module tb_pipeline_hazard_controller;

    localparam int CNT_WIDTH    = 32;
    localparam int DRAIN_CYCLES = 3;
`ifdef PIPELINE_HAZARD_PERF_EN
    localparam int PerfStep = 1;
`else
    localparam int PerfStep = 0;
`endif

    // Expected vector: {PCwrite, IFIDwrite, IDEXbubble, IFIDflush, IDEXflush, EXMEMflush, haltAck}
    localparam logic [6:0] NORM      = 7'b1100000;
    localparam logic [6:0] STALL     = 7'b0010000;
    localparam logic [6:0] HALT      = 7'b0010001;
    localparam logic [6:0] BRANCH    = 7'b1101110;
    localparam logic [6:0] BRANCH_HD = 7'b1101111;

    logic                 CLOCK;
    logic                 RESET;
    logic [4:0]           IFID_rn;
    logic [4:0]           IFID_rm;
    logic                 IFID_usesRm;
    logic                 IDEX_RegWrite;
    logic                 EXMEM_RegWrite;
    logic                 MEMWB_RegWrite;
    logic [4:0]           IDEX_WriteReg;
    logic [4:0]           EXMEM_WriteReg;
    logic [4:0]           MEMWB_WriteReg;
    logic                 EXMEM_takeBranch;
    logic                 haltReq;
    logic                 PCwrite;
    logic                 IFIDwrite;
    logic                 IDEXbubble;
    logic                 IFIDflush;
    logic                 IDEXflush;
    logic                 EXMEMflush;
    logic                 haltAck;
    logic [CNT_WIDTH-1:0] stallCycles;
    logic [CNT_WIDTH-1:0] flushCount;

    int testsRun  = 0;
    int failCount = 0;
    int expStall  = 0;
    int expFlush  = 0;
    logic [6:0] expQ[$];

    pipeline_hazard_controller #(
        .CNT_WIDTH   (CNT_WIDTH),
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .CLOCK           (CLOCK),
        .RESET           (RESET),
        .IFID_rn         (IFID_rn),
        .IFID_rm         (IFID_rm),
        .IFID_usesRm     (IFID_usesRm),
        .IDEX_RegWrite   (IDEX_RegWrite),
        .EXMEM_RegWrite  (EXMEM_RegWrite),
        .MEMWB_RegWrite  (MEMWB_RegWrite),
        .IDEX_WriteReg   (IDEX_WriteReg),
        .EXMEM_WriteReg  (EXMEM_WriteReg),
        .MEMWB_WriteReg  (MEMWB_WriteReg),
        .EXMEM_takeBranch(EXMEM_takeBranch),
        .haltReq         (haltReq),
        .PCwrite         (PCwrite),
        .IFIDwrite       (IFIDwrite),
        .IDEXbubble      (IDEXbubble),
        .IFIDflush       (IFIDflush),
        .IDEXflush       (IDEXflush),
        .EXMEMflush      (EXMEMflush),
        .haltAck         (haltAck),
        .stallCycles     (stallCycles),
        .flushCount      (flushCount)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    function automatic logic [6:0] obsVec();
        return {PCwrite, IFIDwrite, IDEXbubble, IFIDflush, IDEXflush, EXMEMflush, haltAck};
    endfunction

    task automatic clearInputs();
        IFID_rn          = 5'd0;
        IFID_rm          = 5'd0;
        IFID_usesRm      = 1'b0;
        IDEX_RegWrite    = 1'b0;
        EXMEM_RegWrite   = 1'b0;
        MEMWB_RegWrite   = 1'b0;
        IDEX_WriteReg    = 5'd0;
        EXMEM_WriteReg   = 5'd0;
        MEMWB_WriteReg   = 5'd0;
        EXMEM_takeBranch = 1'b0;
    endtask

    task automatic applyStimulus(input logic [6:0] e);
        expQ.push_back(e);
    endtask

    task automatic compareHead(input string tag);
        logic [6:0] e;
        logic [6:0] o;
        testsRun++;
        o = obsVec();
        if (expQ.size() == 0) begin
            failCount++;
            $error("[TB] FAIL %s: observed %b, scoreboard empty", tag, o);
        end else begin
            e = expQ.pop_front();
            assert (o === e) else begin
                failCount++;
                $error("[TB] FAIL %s: observed %b expected %b", tag, o, e);
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        @(negedge CLOCK);
        compareHead(tag);
    endtask

    task automatic step(input string tag, input logic [6:0] e);
        applyStimulus(e);
        checkOutput(tag);
        @(posedge CLOCK);
        #1;
    endtask

    task automatic checkCounters(input string tag);
        testsRun++;
        assert (stallCycles === CNT_WIDTH'(expStall)) else begin
            failCount++;
            $error("[TB] FAIL %s_stall: observed %0d expected %0d", tag, stallCycles, expStall);
        end
        testsRun++;
        assert (flushCount === CNT_WIDTH'(expFlush)) else begin
            failCount++;
            $error("[TB] FAIL %s_flush: observed %0d expected %0d", tag, flushCount, expFlush);
        end
    endtask

    initial begin
        RESET   = 1'b1;
        haltReq = 1'b0;
        clearInputs();
        #2;
        applyStimulus(NORM);
        compareHead("reset_outputs");
        checkCounters("reset");
        @(negedge CLOCK);
        RESET = 1'b0;
        @(posedge CLOCK);
        #1;

        step("idle", NORM);

        // Writes to XZR from every stage must never stall.
        IDEX_RegWrite = 1'b1;  IDEX_WriteReg  = 5'd31;
        EXMEM_RegWrite = 1'b1; EXMEM_WriteReg = 5'd31;
        MEMWB_RegWrite = 1'b1; MEMWB_WriteReg = 5'd31;
        IFID_rn = 5'd31; IFID_rm = 5'd31; IFID_usesRm = 1'b1;
        step("xzr", NORM);
        clearInputs();

        // rm only matters when the instruction actually reads it.
        MEMWB_RegWrite = 1'b1; MEMWB_WriteReg = 5'd9; IFID_rm = 5'd9; IFID_rn = 5'd1;
        step("rm_unused", NORM);
        IFID_usesRm = 1'b1;
        step("rm_memwb_stall", STALL);
        expStall += PerfStep;
        MEMWB_RegWrite = 1'b0;
        step("rm_memwb_done", NORM);
        checkCounters("after_rm");
        clearInputs();

        // Producer in ID/EX drifts down the pipe while bubbles fill behind it.
        IFID_rn = 5'd5;
        IDEX_RegWrite = 1'b1; IDEX_WriteReg = 5'd5;
        step("raw_idex_1", STALL);
        IDEX_RegWrite = 1'b0; EXMEM_RegWrite = 1'b1; EXMEM_WriteReg = 5'd5;
        step("raw_idex_2", STALL);
        EXMEM_RegWrite = 1'b0; MEMWB_RegWrite = 1'b1; MEMWB_WriteReg = 5'd5;
        step("raw_idex_3", STALL);
        MEMWB_RegWrite = 1'b0;
        expStall += 3 * PerfStep;
        step("raw_idex_done", NORM);
        checkCounters("after_raw_idex");

        // Producer already in EX/MEM needs two bubbles.
        IFID_rm = 5'd12; IFID_usesRm = 1'b1;
        EXMEM_RegWrite = 1'b1; EXMEM_WriteReg = 5'd12;
        step("raw_exmem_1", STALL);
        EXMEM_RegWrite = 1'b0; MEMWB_RegWrite = 1'b1; MEMWB_WriteReg = 5'd12;
        step("raw_exmem_2", STALL);
        MEMWB_RegWrite = 1'b0;
        expStall += 2 * PerfStep;
        step("raw_exmem_done", NORM);
        clearInputs();

        // Branch beats RAW in the same cycle and the stall is not counted.
        IFID_rn = 5'd5; IDEX_RegWrite = 1'b1; IDEX_WriteReg = 5'd5; EXMEM_takeBranch = 1'b1;
        step("branch_raw", BRANCH);
        expFlush += PerfStep;
        clearInputs();
        step("branch_raw_after", NORM);
        checkCounters("after_branch_raw");

        // Halt, drain, halted, then resume with the held instruction issuing.
        haltReq = 1'b1;
        step("halt_edge0", NORM);
        for (int i = 0; i < DRAIN_CYCLES; i++) step("halt_drain", STALL);
        step("halted_1", HALT);
        step("halted_2", HALT);
        haltReq = 1'b0;
        step("resume_edge", HALT);
        step("resumed", NORM);

        // Branch in the second drain cycle must not stretch the drain.
        haltReq = 1'b1;
        step("bd_edge0", NORM);
        step("bd_drain1", STALL);
        EXMEM_takeBranch = 1'b1;
        step("bd_drain2_branch", BRANCH);
        expFlush += PerfStep;
        EXMEM_takeBranch = 1'b0;
        step("bd_drain3", STALL);
        step("bd_halted", HALT);
        haltReq = 1'b0;
        step("bd_resume_edge", HALT);
        step("bd_resumed", NORM);
        checkCounters("after_branch_drain");

        // Branch alongside haltReq in RUN defers the drain by a cycle; branch in HALTED flushes.
        haltReq = 1'b1; EXMEM_takeBranch = 1'b1;
        step("bh_branch", BRANCH);
        expFlush += PerfStep;
        EXMEM_takeBranch = 1'b0;
        step("bh_edge0", NORM);
        for (int i = 0; i < DRAIN_CYCLES; i++) step("bh_drain", STALL);
        step("bh_halted", HALT);
        EXMEM_takeBranch = 1'b1;
        step("halted_branch", BRANCH_HD);
        expFlush += PerfStep;
        EXMEM_takeBranch = 1'b0;
        step("halted_after_branch", HALT);
        haltReq = 1'b0;
        step("bh_resume_edge", HALT);
        step("bh_resumed", NORM);
        checkCounters("after_branch_halt");

        // Asynchronous reset in the middle of DRAIN.
        haltReq = 1'b1;
        step("rd_edge0", NORM);
        step("rd_drain1", STALL);
        #2;
        RESET = 1'b1;
        #1;
        applyStimulus(NORM);
        compareHead("reset_mid_drain");
        expStall = 0;
        expFlush = 0;
        checkCounters("reset_mid_drain");
        haltReq = 1'b0;
        @(negedge CLOCK);
        RESET = 1'b0;
        @(posedge CLOCK);
        #1;

        // Asynchronous reset while HALTED drops haltAck without a clock edge.
        haltReq = 1'b1;
        step("rh_edge0", NORM);
        for (int i = 0; i < DRAIN_CYCLES; i++) step("rh_drain", STALL);
        step("rh_halted", HALT);
        #2;
        RESET = 1'b1;
        #1;
        applyStimulus(NORM);
        compareHead("reset_mid_halted");
        haltReq = 1'b0;
        @(negedge CLOCK);
        RESET = 1'b0;
        @(posedge CLOCK);
        #1;
        step("post_reset_idle", NORM);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
